// File: rtl/core_ctrl_pkg.sv
// Shared defines for the xRV32I pipeline control block: bus widths,
// enable levels, FSM state encoding and the flush counter width.
package core_ctrl_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic HoldEnable = 1'b1;
    localparam logic JumpEnable = 1'b1;

    // Instruction address bus is [INST_ADDR_MSB:0]
    localparam int INST_ADDR_MSB = 31;

    // Wide enough for FLUSH_CYCLES-1 up to 14
    localparam int FLUSH_CNT_W = 4;

    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_FLUSH      = 2'b01;
    localparam logic [1:0] ST_STALL      = 2'b10;
    localparam logic [1:0] ST_STALL_PEND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE       = ST_IDLE,
        S_FLUSH      = ST_FLUSH,
        S_STALL      = ST_STALL,
        S_STALL_PEND = ST_STALL_PEND
    } ctrl_state_e;

endpackage

// File: rtl/core_ctrl_pend.sv
// One-entry pending-redirect buffer. An irq redirect always overwrites
// the entry; an ex redirect is only accepted into an empty entry.
module core_ctrl_pend
    import core_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   load_irq,
    input  logic [INST_ADDR_MSB:0] load_addr,
    input  logic                   clear,
    output logic                   valid,
    output logic [INST_ADDR_MSB:0] addr
);

    // Capture, overwrite or clear the buffered redirect
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst == RstEnable) begin
            valid <= 1'b0;
            addr  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load && (!valid || load_irq)) begin
            valid <= 1'b1;
            addr  <= load_addr;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Pipeline control for the xRV32I core: redirect arbitration, hold
// generation, buffered replay of redirects across fetch-bus stalls and
// a FLUSH_CYCLES-long flush window after every redirect.
// Optional feature: define CTRL_BUS_TIMEOUT_EN to release a bus stall
// after TIMEOUT_CYCLES cycles with a one-cycle bus_timeout_out pulse.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_jump_flag_in,
    input  logic [INST_ADDR_MSB:0] ex_jump_addr_in,
    input  logic                   ex_hold_flag_in,
    input  logic                   irq_jump_flag_in,
    input  logic [INST_ADDR_MSB:0] irq_jump_addr_in,
    input  logic                   bus_req_in,
    input  logic                   bus_grant_in,
    output logic                   jump_flag_out,
    output logic [INST_ADDR_MSB:0] jump_addr_out,
    output logic                   hold_flag_out,
    output logic                   flush_out,
    output logic                   bus_timeout_out
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam ctrl_state_e AFTER_ISSUE = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;

    ctrl_state_e             state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                    stall_raw, stall, bus_timeout;
    logic                    jump, hold, flush;
    logic [INST_ADDR_MSB:0]  jump_addr;
    logic                    pend_valid, pend_load, pend_clear;
    logic [INST_ADDR_MSB:0]  pend_addr, pend_load_addr;

    assign stall_raw = bus_req_in & ~bus_grant_in;
    // A timed-out stall is treated as released for that cycle
    assign stall     = stall_raw & ~bus_timeout;

`ifdef CTRL_BUS_TIMEOUT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        in_stall;

    assign in_stall    = (state_q == S_STALL) || (state_q == S_STALL_PEND);
    // Count includes the cycle the stall was first seen in
    assign bus_timeout = in_stall && stall_raw &&
                         (({1'b0, stall_cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES));

    // Stall-cycle count: starts at 1 on entry, cleared on exit
    always_comb begin
        stall_cnt_d = 16'd0;
        if ((state_d == S_STALL) || (state_d == S_STALL_PEND))
            stall_cnt_d = in_stall ? (stall_cnt_q + 16'd1) : 16'd1;
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) stall_cnt_q <= 16'd0;
        else                  stall_cnt_q <= stall_cnt_d;
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign bus_timeout        = 1'b0;
`endif

    core_ctrl_pend u_pend (
        .clk       (clk),
        .rst       (rst),
        .load      (pend_load),
        .load_irq  (irq_jump_flag_in),
        .load_addr (pend_load_addr),
        .clear     (pend_clear),
        .valid     (pend_valid),
        .addr      (pend_addr)
    );

    assign pend_load_addr = irq_jump_flag_in ? irq_jump_addr_in : ex_jump_addr_in;

    // Next-state and output decode from the registered state and inputs
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        jump        = 1'b0;
        jump_addr   = '0;
        hold        = 1'b0;
        flush       = 1'b0;
        pend_load   = 1'b0;
        pend_clear  = 1'b0;

        case (state_q)
            S_FLUSH: begin
                // ex jumps here belong to killed instructions
                flush = 1'b1;
                hold  = stall_raw | ex_hold_flag_in;
                if (irq_jump_flag_in && stall_raw) begin
                    pend_load = 1'b1;
                    state_d   = S_STALL_PEND;
                end else if (irq_jump_flag_in) begin
                    jump        = JumpEnable;
                    jump_addr   = irq_jump_addr_in;
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = AFTER_ISSUE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                    if (flush_cnt_q <= 1) state_d = S_IDLE;
                end
            end
            default: begin
                // IDLE, STALL and STALL_PEND share one decision once the
                // stall drops; the pending entry is only ever valid in
                // STALL_PEND.
                if (stall) begin
                    hold      = HoldEnable;
                    pend_load = irq_jump_flag_in | ex_jump_flag_in;
                    state_d   = (irq_jump_flag_in | ex_jump_flag_in | pend_valid)
                                ? S_STALL_PEND : S_STALL;
                end else if (irq_jump_flag_in | ex_jump_flag_in | pend_valid) begin
                    jump        = JumpEnable;
                    flush       = 1'b1;
                    jump_addr   = irq_jump_flag_in ? irq_jump_addr_in :
                                  pend_valid       ? pend_addr        : ex_jump_addr_in;
                    pend_clear  = 1'b1;
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = AFTER_ISSUE;
                end else begin
                    hold    = ex_hold_flag_in;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and flush-window counter registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted
    assign jump_flag_out   = (rst == RstEnable) ? 1'b0 : jump;
    assign jump_addr_out   = (rst == RstEnable) ? '0   : jump_addr;
    assign hold_flag_out   = (rst == RstEnable) ? 1'b0 : hold;
    assign flush_out       = (rst == RstEnable) ? 1'b0 : flush;
    assign bus_timeout_out = (rst == RstEnable) ? 1'b0 : bus_timeout;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a reference
// model of the redirect/hold/flush rules.
module tb_core_ctrl;

    localparam int FC = 2;
    localparam int TO = 4;
`ifdef CTRL_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_flag_in, ex_hold_flag_in, irq_jump_flag_in;
    logic [31:0] ex_jump_addr_in, irq_jump_addr_in;
    logic        bus_req_in, bus_grant_in;
    logic        jump_flag_out, hold_flag_out, flush_out, bus_timeout_out;
    logic [31:0] jump_addr_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_flush = 0;   // flush cycles still owed, including the current one
    int          m_age   = 0;   // stall cycles already spent holding (0 = not stalled)
    bit          m_pv    = 0;
    logic [31:0] m_pa    = '0;

    // Last observed outputs, for directed constant checks
    logic        obs_j, obs_h, obs_f, obs_t;
    logic [31:0] obs_a;

    core_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_jump_flag_in  (ex_jump_flag_in),
        .ex_jump_addr_in  (ex_jump_addr_in),
        .ex_hold_flag_in  (ex_hold_flag_in),
        .irq_jump_flag_in (irq_jump_flag_in),
        .irq_jump_addr_in (irq_jump_addr_in),
        .bus_req_in       (bus_req_in),
        .bus_grant_in     (bus_grant_in),
        .jump_flag_out    (jump_flag_out),
        .jump_addr_out    (jump_addr_out),
        .hold_flag_out    (hold_flag_out),
        .flush_out        (flush_out),
        .bus_timeout_out  (bus_timeout_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance.
    task automatic cyc(input logic r, input logic exj, input logic [31:0] exa, input logic exh,
                       input logic irq, input logic [31:0] irqa, input logic req, input logic gnt);
        bit          stall, tmo;
        bit          e_j, e_h, e_f, e_t;
        logic [31:0] e_a;
        int          n_flush, n_age;
        bit          n_pv;
        logic [31:0] n_pa;

        @(negedge clk);
        rst = r; ex_jump_flag_in = exj; ex_jump_addr_in = exa; ex_hold_flag_in = exh;
        irq_jump_flag_in = irq; irq_jump_addr_in = irqa; bus_req_in = req; bus_grant_in = gnt;
        #1;

        e_j = 0; e_a = '0; e_h = 0; e_f = 0; e_t = 0;
        n_flush = m_flush; n_age = 0; n_pv = m_pv; n_pa = m_pa;
        stall = req && !gnt;

        if (r) begin
            n_flush = 0; n_pv = 0; n_pa = '0;
        end else if (m_flush > 0) begin
            e_f = 1;
            e_h = stall || exh;
            if (irq && stall) begin
                n_pv = 1; n_pa = irqa; n_flush = 0; n_age = 1;
            end else if (irq) begin
                e_j = 1; e_a = irqa; n_flush = FC - 1;
            end else begin
                n_flush = m_flush - 1;
            end
        end else begin
            tmo = TO_EN && (m_age > 0) && stall && (m_age + 1 >= TO);
            e_t = tmo;
            if (stall && !tmo) begin
                e_h = 1;
                n_age = m_age + 1;
                if (irq) begin
                    n_pv = 1; n_pa = irqa;
                end else if (exj && !m_pv) begin
                    n_pv = 1; n_pa = exa;
                end
            end else if (irq || m_pv || exj) begin
                e_j = 1; e_f = 1;
                e_a = irq ? irqa : (m_pv ? m_pa : exa);
                n_pv = 0; n_flush = FC - 1;
            end else begin
                e_h = exh;
            end
        end

        obs_j = jump_flag_out; obs_a = jump_addr_out; obs_h = hold_flag_out;
        obs_f = flush_out;     obs_t = bus_timeout_out;
        check("jump_flag", obs_j, e_j);
        check("jump_addr", obs_a, e_a);
        check("hold_flag", obs_h, e_h);
        check("flush",     obs_f, e_f);
        check("timeout",   obs_t, e_t);

        @(posedge clk);
        m_flush = n_flush; m_age = n_age; m_pv = n_pv; m_pa = n_pa;
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        int stall_left = 0;

        // Reset with busy inputs: outputs must stay low
        cyc(1, 1, 32'h104, 1, 1, 32'h88, 1, 0);
        check("rst_jump", obs_j, 1'b0);
        check("rst_hold", obs_h, 1'b0);
        cyc(1, 0, '0, 0, 0, '0, 0, 0);
        idle();
        check("post_rst_jump",  obs_j, 1'b0);
        check("post_rst_flush", obs_f, 1'b0);

        // ex jump in IDLE, no stall
        cyc(0, 1, 32'h100, 0, 0, '0, 0, 0);
        check("ex_jump", obs_j, 1'b1);
        check("ex_addr", obs_a, 32'h100);
        idle();
        check("ex_flush2", obs_f, 1'b1);
        idle();
        check("ex_flush_end", obs_f, 1'b0);

        // irq beats a simultaneous ex jump
        cyc(0, 1, 32'h200, 0, 1, 32'h80, 0, 0);
        check("prio_addr", obs_a, 32'h80);
        idle(); idle();
        check("prio_ex_dropped", obs_j, 1'b0);

`ifndef CTRL_BUS_TIMEOUT_EN
        // 5-cycle stall with an ex jump arriving in its 2nd cycle
        for (int i = 1; i <= 5; i++) begin
            cyc(0, i == 2, 32'h40, 0, 0, '0, 1, 0);
            check("stall_hold", obs_h, 1'b1);
            check("stall_nojump", obs_j, 1'b0);
        end
        cyc(0, 0, '0, 0, 0, '0, 1, 1);
        check("replay_jump", obs_j, 1'b1);
        check("replay_addr", obs_a, 32'h40);
        idle();
        check("replay_flush2", obs_f, 1'b1);
        idle();
`endif

        // Pending ex overwritten by irq during the stall
        cyc(0, 1, 32'h40, 0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 1, 32'h80, 1, 0);
        cyc(0, 1, 32'h44, 0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0, '0, 1, 1);
        check("overwrite_addr", obs_a, 32'h80);
        idle(); idle();
        check("overwrite_once", obs_j, 1'b0);

        // irq during FLUSH restarts the window; ex during FLUSH ignored
        cyc(0, 1, 32'h100, 0, 0, '0, 0, 0);
        cyc(0, 0, '0, 0, 1, 32'h300, 0, 0);
        check("flush_irq_addr", obs_a, 32'h300);
        cyc(0, 1, 32'h500, 0, 0, '0, 0, 0);
        check("flush_ex_ignored", obs_j, 1'b0);
        check("flush_restarted", obs_f, 1'b1);
        idle();
        check("flush_restart_end", obs_f, 1'b0);

`ifdef CTRL_BUS_TIMEOUT_EN
        // Stall held: timeout pulses in the 4th stall cycle, hold drops
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, '0, 0, 0, '0, 1, 0);
            check("to_wait", obs_t, 1'b0);
        end
        cyc(0, 0, '0, 0, 0, '0, 1, 0);
        check("to_pulse", obs_t, 1'b1);
        check("to_hold_release", obs_h, 1'b0);
        idle();
`endif

        // Reset in the middle of STALL_PEND discards the redirect
        cyc(0, 1, 32'h600, 0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0, '0, 1, 0);
        cyc(1, 0, '0, 0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0, '0, 1, 1);
        check("rst_drop_pend", obs_j, 1'b0);
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, exj, exh, irq, req, gnt;
            logic [31:0] exa, irqa;
            r    = ($urandom_range(0, 199) == 0);
            exj  = ($urandom_range(0, 3) == 0);
            exh  = ($urandom_range(0, 4) == 0);
            irq  = ($urandom_range(0, 9) == 0);
            exa  = {$urandom_range(0, 32'hffff), 2'b00};
            irqa = {$urandom_range(0, 32'hffff), 2'b00};
            if (stall_left == 0 && $urandom_range(0, 5) == 0)
                stall_left = $urandom_range(1, 8);
            if (stall_left > 0) begin
                req = 1; gnt = 0; stall_left--;
            end else begin
                req = 1'($urandom_range(0, 1));
                gnt = 1'($urandom_range(0, 1));
            end
            cyc(r, exj, exa, exh, irq, irqa, req, gnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
